// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// ID-stage RAW hazard / stall controller for the pipelined MIPS core.
// The ID source registers (rs, rt) are compared against NUM_STAGES downstream
// write ports (stage 0 = EX, the nearest). When a match is found, stall_out
// is held for a number of cycles that depends on how far away the producer
// is. While stall_out is high, PC/IF/ID freeze and a bubble goes into EX.
// All state changes on the falling edge of clock, so a stall decision is
// ready before the next rising edge.
//
// Optional feature macro: FORWARDING_EN
//   undefined : full interlock. fwd_* are tied to 0 and wr_is_load_in is unused.
//   defined   : only a load in EX (stage 0) that feeds ID stalls, for exactly
//               one cycle. Every other match is resolved through the forwarding
//               selects, which are forced to 0 while a stall is active.
//
// Ports
//   clock              pipeline clock (state updates on negedge)
//   reset              asynchronous, active-high; forces the startup stall
//   id_valid_in        ID holds a real instruction
//   rs/rt_address_in   ID source register addresses
//   rs/rt_read_enable_in  source actually read
//   wr_enable_in       per-stage write enable, bit k = stage k
//   wr_address_in      per-stage destination address, slice k = stage k
//   wr_is_load_in      per-stage "result comes from memory"
//   flush_in           branch/exception flush; aborts a pending stall
//   stall_out          freeze PC/IF/ID, bubble into EX
//   stall_remain_out   stall cycles remaining after the current one
//   stall_cycles_out   saturating count of cycles with stall_out=1
//   fwd_rs/rt_sel_out  operand source: 0 = regfile, k+1 = stage k
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = 32,
    parameter int MASK_R0    = 1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                id_valid_in,
    input  logic [ADDR_W-1:0]                   rs_address_in,
    input  logic [ADDR_W-1:0]                   rt_address_in,
    input  logic                                rs_read_enable_in,
    input  logic                                rt_read_enable_in,
    input  logic [NUM_STAGES-1:0]               wr_enable_in,
    input  logic [NUM_STAGES*ADDR_W-1:0]        wr_address_in,
    input  logic [NUM_STAGES-1:0]               wr_is_load_in,
    input  logic                                flush_in,
    output logic                                stall_out,
    output logic [$clog2(NUM_STAGES+1)-1:0]     stall_remain_out,
    output logic [CNT_W-1:0]                    stall_cycles_out,
    output logic [$clog2(NUM_STAGES+1)-1:0]     fwd_rs_sel_out,
    output logic [$clog2(NUM_STAGES+1)-1:0]     fwd_rt_sel_out
);

    localparam int SEL_W = $clog2(NUM_STAGES + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [SEL_W-1:0] remain_reg, remain_next;
    logic [CNT_W-1:0] cycles_reg, cycles_next;

    // ---------------------------------------------------------------------
    // Per-stage address comparison. A destination of R0 never matches when
    // MASK_R0 is set, since R0 is hardwired to zero.
    // ---------------------------------------------------------------------
    logic [NUM_STAGES-1:0] rs_hit;
    logic [NUM_STAGES-1:0] rt_hit;
    logic [NUM_STAGES-1:0] stage_hit;

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_cmp
            logic [ADDR_W-1:0] dest;
            logic              dest_masked;

            assign dest        = wr_address_in[gi*ADDR_W +: ADDR_W];
            assign dest_masked = (MASK_R0 != 0) && (dest == '0);
            assign rs_hit[gi]  = wr_enable_in[gi] && rs_read_enable_in &&
                                 (dest == rs_address_in) && !dest_masked;
            assign rt_hit[gi]  = wr_enable_in[gi] && rt_read_enable_in &&
                                 (dest == rt_address_in) && !dest_masked;
            assign stage_hit[gi] = rs_hit[gi] | rt_hit[gi];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Hazard detection: does the ID instruction need to wait, and for how
    // long (expressed as the remain value loaded on the stall edge, i.e.
    // stall length minus one).
    // ---------------------------------------------------------------------
    logic             hazard;
    logic [SEL_W-1:0] hazard_remain;

`ifdef FORWARDING_EN
    // Only a load still in EX cannot be forwarded in time; one bubble suffices.
    assign hazard        = stage_hit[0] & wr_is_load_in[0];
    assign hazard_remain = '0;

    // Nearest producer wins for each operand. Walk from the far end so the
    // last assignment is the lowest matching stage.
    always_comb begin
        fwd_rs_sel_out = '0;
        fwd_rt_sel_out = '0;
        if (state_reg == IDLE) begin
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (rs_hit[k]) fwd_rs_sel_out = SEL_W'(k + 1);
                if (rt_hit[k]) fwd_rt_sel_out = SEL_W'(k + 1);
            end
        end
    end
`else
    // Nearest producer wins; it needs the longest wait (NUM_STAGES - k).
    always_comb begin
        hazard        = 1'b0;
        hazard_remain = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (stage_hit[k]) begin
                hazard        = 1'b1;
                hazard_remain = SEL_W'(NUM_STAGES - 1 - k);
            end
        end
    end

    assign fwd_rs_sel_out = '0;
    assign fwd_rt_sel_out = '0;

    logic unused_load;
    assign unused_load = &{1'b0, wr_is_load_in};
`endif

    // ---------------------------------------------------------------------
    // Stall FSM. Flush beats everything. The release edge (STALL with
    // remain==0) performs no hazard check; the next edge does.
    // ---------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        remain_next = remain_reg;
        cycles_next = cycles_reg;

        // Count cycles already spent stalled; stick at all-ones.
        if (state_reg == STALL && cycles_reg != '1) begin
            cycles_next = cycles_reg + CNT_W'(1);
        end

        if (flush_in) begin
            state_next  = IDLE;
            remain_next = '0;
        end else if (state_reg == STALL) begin
            if (remain_reg != '0) begin
                remain_next = remain_reg - SEL_W'(1);
            end else begin
                state_next = IDLE;
            end
        end else if (id_valid_in && hazard) begin
            state_next  = STALL;
            remain_next = hazard_remain;
        end
    end

    // Reset parks the pipeline in a one-cycle startup stall.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= STALL;
            remain_reg <= '0;
            cycles_reg <= '0;
        end else begin
            state_reg  <= state_next;
            remain_reg <= remain_next;
            cycles_reg <= cycles_next;
        end
    end

    assign stall_out        = (state_reg == STALL);
    assign stall_remain_out = remain_reg;
    assign stall_cycles_out = cycles_reg;

endmodule
